// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word memory with byte-strobe writes,
// optional wait states and PSLVERR on bad addresses.
// Ports: PCLK, PRESETn (async, active low), PSEL, PENABLE, PWRITE, PADDR,
// PWDATA, PSTRB in; PREADY, PRDATA, PSLVERR out.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states (4-bit counter).
module apb_slave_mem #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e           state_q, state_d;
  state_e           phase;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic             err_q, err_d;
  logic [31:0]      prdata_q, prdata_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [IDX_W-1:0] p_idx;
  logic             bad_addr;
  logic             cnt_zero;

  // DEPTH is a power of two, so every index value is in range;
  // only misalignment or high address bits can be bad.
  assign p_idx    = PADDR[IDX_W+1:2];
  assign bad_addr = (PADDR[1:0] != 2'b00)
                  | (PADDR[ADDR_W-1:IDX_W+2] != '0);

  // The setup phase is seen on the bus while the register sits idle,
  // so SETUP is decoded from the bus rather than stored.
  always_comb begin
    phase = IDLE;
    if (state_q == ACCESS) begin
      phase = ACCESS;
    end else if (PSEL && !PENABLE) begin
      phase = SETUP;
    end
  end

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  assign cnt_zero = (cnt_q == 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (phase == SETUP) begin
      cnt_d = 4'(WAIT_CYCLES);
    end else if (phase == ACCESS) begin
      if (!PSEL) begin
        cnt_d = 4'd0;
      end else if (!cnt_zero) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_wait;

  assign unused_wait = (WAIT_CYCLES != 0);
  assign cnt_zero    = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;
    unique case (phase)
      IDLE: begin
      end
      SETUP: begin
        idx_d    = p_idx;
        wr_d     = PWRITE;
        wdata_d  = PWDATA;
        strb_d   = PSTRB;
        err_d    = bad_addr;
        prdata_d = bad_addr ? 32'h0 : mem_q[p_idx];
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d  = IDLE;
          err_d    = 1'b0;
          prdata_d = 32'h0;
        end else if (cnt_zero) begin
          state_d = IDLE;
          if (wr_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
              if (strb_q[b]) begin
                mem_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= 32'h0;
      strb_q   <= 4'h0;
      err_q    <= 1'b0;
      prdata_q <= 32'h0;
      mem_q    <= '{default: 32'h0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      mem_q    <= mem_d;
    end
  end

  assign PREADY  = (state_q == ACCESS) & cnt_zero;
  assign PRDATA  = prdata_q;
  assign PSLVERR = err_q & PREADY;

endmodule
